// File: rtl/lsb_serializer_if.sv
// lsb_serializer_if: load handshake and serial output bundle for lsb_serializer.
// master = the word producer / stream consumer side, slave = the serializer.
interface lsb_serializer_if #(
    parameter int DATA_SIZE = 8
);
    logic                 load_valid;
    logic                 load_ready;
    logic [DATA_SIZE-1:0] d;
    logic                 q_serial;
    logic                 q_valid;
    logic                 q_first;
    logic                 q_last;
    logic                 done;

    modport master (
        output load_valid,
        output d,
        input  load_ready,
        input  q_serial,
        input  q_valid,
        input  q_first,
        input  q_last,
        input  done
    );

    modport slave (
        input  load_valid,
        input  d,
        output load_ready,
        output q_serial,
        output q_valid,
        output q_first,
        output q_last,
        output done
    );
endinterface

// File: rtl/lsb_serializer.sv
// lsb_serializer: parallel-in, serial-out transmitter, LSB first, with
// first/last framing strobes, a done pulse and gap-free back-to-back frames.
// Optional feature: define SERIALIZER_PARITY_EN to append an even-parity bit
// to every frame (frame length becomes DATA_SIZE+1).
module lsb_serializer #(
    parameter int DATA_SIZE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    lsb_serializer_if.slave  bus
);

`ifdef SERIALIZER_PARITY_EN
    localparam int FRAME_LEN = DATA_SIZE + 1;
`else
    localparam int FRAME_LEN = DATA_SIZE;
`endif
    localparam int             CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_SIZE-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 q_serial_q, q_serial_d;
    logic                 q_valid_q, q_valid_d;
    logic                 q_first_q, q_first_d;
    logic                 q_last_q, q_last_d;
    logic                 done_q, done_d;
`ifdef SERIALIZER_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    logic at_last;
    logic accept;
    logic next_bit;

    // The final frame bit is on the line; a new word may replace it seamlessly.
    assign at_last        = (state_q == SHIFT) && (cnt_q == LAST);
    assign bus.load_ready = en && ((state_q == IDLE) || at_last);
    assign accept         = bus.load_valid && bus.load_ready;

    // Bit that follows the one currently on q_serial (parity slot after the last data bit).
    always_comb begin
`ifdef SERIALIZER_PARITY_EN
        next_bit = (cnt_q == CNT_W'(DATA_SIZE - 1)) ? parity_q : sr_q[1];
`else
        next_bit = sr_q[1];
`endif
    end

    // Next-state logic: accept, shift, or end-of-frame; everything holds when en=0.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        q_serial_d = q_serial_q;
        q_valid_d  = q_valid_q;
        q_first_d  = q_first_q;
        done_d     = 1'b0;
`ifdef SERIALIZER_PARITY_EN
        parity_d   = parity_q;
`endif
        if (en) begin
            done_d = at_last;
            if (accept) begin
                state_d    = SHIFT;
                sr_d       = bus.d;
                cnt_d      = '0;
                q_serial_d = bus.d[0];
                q_valid_d  = 1'b1;
                q_first_d  = 1'b1;
`ifdef SERIALIZER_PARITY_EN
                parity_d   = ^bus.d;
`endif
            end else if (state_q == SHIFT) begin
                if (cnt_q != LAST) begin
                    sr_d       = {1'b0, sr_q[DATA_SIZE-1:1]};
                    cnt_d      = cnt_q + CNT_W'(1);
                    q_serial_d = next_bit;
                    q_first_d  = 1'b0;
                end else begin
                    state_d    = IDLE;
                    q_serial_d = 1'b0;
                    q_valid_d  = 1'b0;
                    q_first_d  = 1'b0;
                end
            end
        end
        q_last_d = (state_d == SHIFT) && (cnt_d == LAST);
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            cnt_q      <= '0;
            q_serial_q <= 1'b0;
            q_valid_q  <= 1'b0;
            q_first_q  <= 1'b0;
            q_last_q   <= 1'b0;
            done_q     <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            q_serial_q <= q_serial_d;
            q_valid_q  <= q_valid_d;
            q_first_q  <= q_first_d;
            q_last_q   <= q_last_d;
            done_q     <= done_d;
`ifdef SERIALIZER_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // During data bits the line must mirror the low end of the shift register.
    always_ff @(posedge clk) begin
        if (rst_n && (state_q == SHIFT) && (int'(cnt_q) < DATA_SIZE)) begin
            assert (q_serial_q == sr_q[0]);
        end
    end

    assign bus.q_serial = q_serial_q;
    assign bus.q_valid  = q_valid_q;
    assign bus.q_first  = q_first_q;
    assign bus.q_last   = q_last_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_lsb_serializer.sv
// tb_lsb_serializer: scoreboard bench for lsb_serializer. Each accepted word
// is expanded into its expected frame (bits LSB first, parity appended when
// SERIALIZER_PARITY_EN is defined) and queued; a negedge monitor compares the
// line against the queue head, consuming one entry per enabled cycle.
module tb_lsb_serializer;
    localparam int DS = 8;
`ifdef SERIALIZER_PARITY_EN
    localparam int FL = DS + 1;
`else
    localparam int FL = DS;
`endif

    typedef struct packed {
        logic b;
        logic first;
        logic last;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b1;
    int   en_mode = 0;   // 0: en=1, 1: en=0, 2: random
    int   n_cmp = 0;
    int   n_bad = 0;
    logic exp_done = 1'b0;
    exp_t sb[$];

    lsb_serializer_if #(.DATA_SIZE(DS)) bus ();

    lsb_serializer #(.DATA_SIZE(DS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Enable driver, updated shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        case (en_mode)
            0:       en = 1'b1;
            1:       en = 1'b0;
            default: en = ($urandom_range(0, 3) != 0);
        endcase
    end

    function automatic void chk(string name, logic act, logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference frame for a word: data bits LSB first, then optional even parity.
    task automatic push_frame(input logic [DS-1:0] w);
        logic par;
        exp_t e;
        par = 1'b0;
        for (int i = 0; i < DS; i++) par = par ^ w[i];
        for (int i = 0; i < FL; i++) begin
            e.b     = (i < DS) ? w[i] : par;
            e.first = (i == 0);
            e.last  = (i == FL - 1);
            sb.push_back(e);
        end
        $display("word %02h accepted at %0t", w, $time);
    endtask

    // Offer a word until the DUT takes it; returns just after the accepting edge.
    task automatic send(input logic [DS-1:0] w);
        bit ok;
        ok = 1'b0;
        bus.load_valid = 1'b1;
        bus.d          = w;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.load_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.load_valid = 1'b0;
        bus.d          = DS'($urandom);
        chk("accept_timeout", ok, 1'b1);
        if (ok) push_frame(w);
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            sb.delete();
            chk("rst_q_serial", bus.q_serial, 1'b0);
            chk("rst_q_valid", bus.q_valid, 1'b0);
            chk("rst_q_first", bus.q_first, 1'b0);
            chk("rst_q_last", bus.q_last, 1'b0);
            chk("rst_done", bus.done, 1'b0);
            chk("rst_load_ready", bus.load_ready, en);
        end
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compare the line with the scoreboard head every cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_done = 1'b0;
        end else begin
            chk("load_ready", bus.load_ready, en && (sb.size() <= 1));
            chk("done", bus.done, exp_done);
            if (sb.size() != 0) begin
                e = sb[0];
                chk("q_valid", bus.q_valid, 1'b1);
                chk("q_serial", bus.q_serial, e.b);
                chk("q_first", bus.q_first, e.first);
                chk("q_last", bus.q_last, e.last);
                if (en) begin
                    e = sb.pop_front();
                    exp_done = e.last;
                end else begin
                    exp_done = 1'b0;
                end
            end else begin
                chk("idle_q_valid", bus.q_valid, 1'b0);
                chk("idle_q_serial", bus.q_serial, 1'b0);
                chk("idle_q_first", bus.q_first, 1'b0);
                chk("idle_q_last", bus.q_last, 1'b0);
                exp_done = 1'b0;
            end
        end
    end

    initial begin
        bit drained;
        bus.load_valid = 1'b0;
        bus.d          = '0;
        @(posedge clk);
        #1;
        do_reset(2);

        // Basic frame.
        send(8'hA5);
        idle(FL + 2);

        // Back-to-back frames.
        send(8'h01);
        send(8'h80);
        idle(FL + 2);

        // Enable gating after bit 2.
        send(8'h3C);
        idle(2);
        en_mode = 1;
        idle(3);
        en_mode = 0;
        idle(FL + 2);

        // Mid-frame reset after bit 4, then a fresh frame.
        send(8'hFF);
        idle(4);
        do_reset(1);
        idle(2);
        send(8'h0F);
        idle(FL + 2);

        // Word offered during an active frame must wait for the last bit.
        send(8'hAA);
        send(8'h55);
        idle(FL + 2);

        // Parity-relevant words.
        send(8'h07);
        send(8'h03);
        idle(FL + 2);

        // Randomized words, random enable, random gaps.
        en_mode = 2;
        for (int n = 0; n < 40; n++) begin
            send(DS'($urandom));
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
        end
        en_mode = 0;

        drained = 1'b0;
        for (int i = 0; i < 100; i++) begin
            idle(1);
            if (sb.size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
        idle(3);
        chk("drain", drained, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
